// File: rtl/keystream_arbiter.sv
// Round-robin arbiter sharing one XTEA keystream byte generator between two requesters.
// Optional per-requester delivery and timeout statistics: define KEYSTREAM_ARB_STATS_EN.
//
// state   | meaning
// IDLE    | sample req, grant round-robin, latch owner
// ISSUE   | hash_req_pulse high, watchdog cleared
// WAIT    | waiting for generator byte pulse, watchdog running
// DELIVER | byte_valid[owner] raised on the next cycle, last_grant updated
module keystream_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [1:0] req,
    input  logic       flush,
    input  logic [7:0] hash_byte_in,
    input  logic       hash_byte_pulse_in,
    output logic       hash_req_pulse,
    output logic       reset_hash_out,
    output logic [7:0] byte_out,
    output logic [1:0] byte_valid,
    output logic       busy,
    output logic       timeout_err
`ifdef KEYSTREAM_ARB_STATS_EN
    ,
    output logic [15:0] grant_count0,
    output logic [15:0] grant_count1,
    output logic [7:0]  timeout_count
`endif
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        DELIVER = 2'd3
    } state_t;

    state_t        state;
    logic          owner;
    logic          last_grant;
    logic [CW-1:0] wd_cnt;
    logic          grant_sel;

    // With both requesting, the one not served last wins.
    always_comb begin
        grant_sel = 1'b0;
        case (req)
            2'b10:   grant_sel = 1'b1;
            2'b11:   grant_sel = ~last_grant;
            default: grant_sel = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state          <= IDLE;
            owner          <= 1'b0;
            last_grant     <= 1'b1;
            wd_cnt         <= '0;
            hash_req_pulse <= 1'b0;
            reset_hash_out <= 1'b0;
            byte_out       <= 8'h00;
            byte_valid     <= 2'b00;
            busy           <= 1'b0;
            timeout_err    <= 1'b0;
`ifdef KEYSTREAM_ARB_STATS_EN
            grant_count0   <= 16'h0000;
            grant_count1   <= 16'h0000;
            timeout_count  <= 8'h00;
`endif
        end else begin
            hash_req_pulse <= 1'b0;
            reset_hash_out <= 1'b0;
            byte_valid     <= 2'b00;
            if (flush) begin
                // Flush beats any coincident generator pulse or watchdog expiry.
                state          <= IDLE;
                reset_hash_out <= 1'b1;
                timeout_err    <= 1'b0;
                last_grant     <= 1'b1;
                busy           <= 1'b0;
                wd_cnt         <= '0;
`ifdef KEYSTREAM_ARB_STATS_EN
                grant_count0   <= 16'h0000;
                grant_count1   <= 16'h0000;
                timeout_count  <= 8'h00;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (req != 2'b00) begin
                            owner          <= grant_sel;
                            state          <= ISSUE;
                            hash_req_pulse <= 1'b1;
                            busy           <= 1'b1;
                        end
                    end
                    ISSUE: begin
                        wd_cnt <= '0;
                        state  <= WAIT;
                    end
                    WAIT: begin
                        if (hash_byte_pulse_in) begin
                            byte_out <= hash_byte_in;
                            state    <= DELIVER;
                        end else if (wd_cnt == WD_LAST) begin
                            // last_grant untouched so a held request is re-granted.
                            reset_hash_out <= 1'b1;
                            timeout_err    <= 1'b1;
                            state          <= IDLE;
                            busy           <= 1'b0;
`ifdef KEYSTREAM_ARB_STATS_EN
                            if (timeout_count != 8'hFF)
                                timeout_count <= timeout_count + 8'h01;
`endif
                        end else if (wd_cnt != {CW{1'b1}}) begin
                            wd_cnt <= wd_cnt + 1'b1;
                        end
                    end
                    DELIVER: begin
                        byte_valid <= owner ? 2'b10 : 2'b01;
                        last_grant <= owner;
                        state      <= IDLE;
                        busy       <= 1'b0;
`ifdef KEYSTREAM_ARB_STATS_EN
                        if (owner)
                            grant_count1 <= grant_count1 + 16'h0001;
                        else
                            grant_count0 <= grant_count0 + 16'h0001;
`endif
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keystream_arbiter.sv
// Directed bench for keystream_arbiter with a one-cycle-latency generator model and a delivery scoreboard.
module tb_keystream_arbiter;

    logic       clk = 1'b0;
    logic       nrst;
    logic [1:0] req;
    logic       flush;
    logic [7:0] hash_byte_in;
    logic       hash_byte_pulse_in;
    logic       hash_req_pulse;
    logic       reset_hash_out;
    logic [7:0] byte_out;
    logic [1:0] byte_valid;
    logic       busy;
    logic       timeout_err;
`ifdef KEYSTREAM_ARB_STATS_EN
    logic [15:0] grant_count0;
    logic [15:0] grant_count1;
    logic [7:0]  timeout_count;
`endif

    keystream_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk                (clk),
        .nrst               (nrst),
        .req                (req),
        .flush              (flush),
        .hash_byte_in       (hash_byte_in),
        .hash_byte_pulse_in (hash_byte_pulse_in),
        .hash_req_pulse     (hash_req_pulse),
        .reset_hash_out     (reset_hash_out),
        .byte_out           (byte_out),
        .byte_valid         (byte_valid),
        .busy               (busy),
        .timeout_err        (timeout_err)
`ifdef KEYSTREAM_ARB_STATS_EN
        ,
        .grant_count0       (grant_count0),
        .grant_count1       (grant_count1),
        .timeout_count      (timeout_count)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rq_cnt   = 0;
    int dv_cnt   = 0;
    int rq_cyc   = 0;
    int dv_cyc   = 0;
    logic       gen_en   = 1'b0;
    logic       gen_prev = 1'b0;
    logic [7:0] gen_byte = 8'h00;
    logic [7:0] last_byte = 8'h00;
    logic [9:0] sb_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Generator model: byte pulse one cycle after the request pulse.
    initial forever begin
        @(posedge clk);
        #1;
        if (gen_en) begin
            hash_byte_pulse_in = gen_prev;
            if (gen_prev) begin
                hash_byte_in = gen_byte;
                gen_byte     = gen_byte + 8'h01;
            end
        end
        gen_prev = hash_req_pulse;
    end

    // Monitor: count request pulses, score every delivered byte.
    initial forever begin
        logic [9:0] exp;
        @(negedge clk);
        if (hash_req_pulse === 1'b1) begin
            rq_cnt++;
            rq_cyc = cyc;
        end
        if (byte_valid !== 2'b00) begin
            dv_cnt++;
            dv_cyc = cyc;
            exp = (sb_q.size() != 0) ? sb_q.pop_front() : 10'h000;
            chk("delivery", {22'd0, byte_valid, byte_out}, {22'd0, exp});
        end
    end

    task automatic push(input logic [1:0] who, input logic [7:0] b);
        sb_q.push_back({who, b});
        last_byte = b;
    endtask

    task automatic wait_dv(input string tag, input int target);
        for (int i = 0; i < 80; i++) begin
            if (dv_cnt >= target) break;
            @(negedge clk);
            #1;
        end
        chk(tag, dv_cnt, target);
    endtask

    task automatic wait_rq(input string tag, input int target);
        for (int i = 0; i < 80; i++) begin
            if (rq_cnt >= target) break;
            @(negedge clk);
            #1;
        end
        chk(tag, rq_cnt, target);
    endtask

    initial begin
        int base_rq;
        int base_dv;
        int k;
        nrst = 1'b0;
        req = 2'b00;
        flush = 1'b0;
        hash_byte_in = 8'h00;
        hash_byte_pulse_in = 1'b0;
        #12;
        chk("reset_outs", {hash_req_pulse, reset_hash_out, byte_out, byte_valid, busy, timeout_err}, 0);
        @(posedge clk);
        #1;
        nrst = 1'b1;

        // Single request from requester 0.
        gen_en = 1'b1;
        gen_byte = 8'hA5;
        push(2'b01, 8'hA5);
        @(negedge clk);
        #1;
        req = 2'b01;
        wait_dv("single_dv", 1);
        req = 2'b00;
        chk("single_rq_count", rq_cnt, 1);
        chk("single_latency", dv_cyc - rq_cyc, 3);
        repeat (3) @(negedge clk);
        #1;
        chk("single_idle_busy", busy, 0);

        // Flush while idle: restores round-robin start at requester 0.
        flush = 1'b1;
        @(negedge clk);
        #1;
        flush = 1'b0;
        chk("flush_idle_rst", reset_hash_out, 1);
        @(negedge clk);
        #1;
        chk("flush_idle_rst_end", reset_hash_out, 0);

        // Round robin with both requesters held.
        base_rq = rq_cnt;
        base_dv = dv_cnt;
        gen_byte = 8'h10;
        push(2'b01, 8'h10);
        push(2'b10, 8'h11);
        push(2'b01, 8'h12);
        push(2'b10, 8'h13);
        req = 2'b11;
        wait_dv("rr_dv", base_dv + 4);
        req = 2'b00;
        repeat (3) @(negedge clk);
        #1;
        chk("rr_rq_count", rq_cnt - base_rq, 4);
        chk("rr_sb_drained", sb_q.size(), 0);

        // Watchdog: generator silent.
        gen_en = 1'b0;
        hash_byte_pulse_in = 1'b0;
        base_rq = rq_cnt;
        base_dv = dv_cnt;
        req = 2'b10;
        wait_rq("to_issue", base_rq + 1);
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            #1;
            if (reset_hash_out === 1'b1) begin
                k = i;
                break;
            end
        end
        chk("to_latency", k, 9);
        chk("to_err_set", timeout_err, 1);
        @(negedge clk);
        #1;
        chk("to_reissue", hash_req_pulse, 1);
        chk("to_err_sticky", timeout_err, 1);
        chk("to_no_byte", dv_cnt, base_dv);
        req = 2'b00;

        // Flush coinciding with a generator pulse in WAIT.
        @(negedge clk);
        #1;
        chk("fl_busy_wait", busy, 1);
        flush = 1'b1;
        hash_byte_in = 8'h3C;
        hash_byte_pulse_in = 1'b1;
        @(negedge clk);
        #1;
        flush = 1'b0;
        hash_byte_pulse_in = 1'b0;
        chk("fl_rst_pulse", reset_hash_out, 1);
        chk("fl_busy", busy, 0);
        chk("fl_err_clear", timeout_err, 0);
        @(negedge clk);
        #1;
        chk("fl_rst_end", reset_hash_out, 0);
        chk("fl_no_req", hash_req_pulse, 0);
        chk("fl_no_byte", dv_cnt, base_dv);
        chk("fl_byte_out", byte_out, last_byte);

        // Stray generator pulse while idle.
        hash_byte_in = 8'hFF;
        hash_byte_pulse_in = 1'b1;
        @(negedge clk);
        #1;
        hash_byte_pulse_in = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("stray_valid", byte_valid, 0);
        chk("stray_busy", busy, 0);
        chk("stray_byte_out", byte_out, last_byte);
        chk("stray_no_byte", dv_cnt, base_dv);

        // Asynchronous reset while in WAIT.
        base_rq = rq_cnt;
        req = 2'b01;
        wait_rq("ar_issue", base_rq + 1);
        req = 2'b00;
        @(negedge clk);
        #1;
        chk("ar_busy_wait", busy, 1);
        #1;
        nrst = 1'b0;
        #1;
        chk("ar_outs", {hash_req_pulse, reset_hash_out, byte_out, byte_valid, busy, timeout_err}, 0);
        @(posedge clk);
        #1;
        base_dv = dv_cnt;
        gen_en = 1'b1;
        gen_byte = 8'h5A;
        push(2'b01, 8'h5A);
        req = 2'b11;
        nrst = 1'b1;
        wait_dv("ar_first_dv", base_dv + 1);
        req = 2'b00;
        repeat (4) @(negedge clk);
        #1;
        chk("final_sb_empty", sb_q.size(), 0);
        chk("final_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
